// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC fetch/commit sequencer: FSM state codes,
// PC increment and a word-alignment helper.
package pc_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Clears the byte-offset bits so a target always lands on a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_pc_next_calc.sv
// Combinational next-PC selection for pc_fetch_sequencer.
// Priority: jump-register > jump > taken branch > sequential.
module pc_next_calc (
    input  logic [31:0] pc_plus4,
    input  logic        ex_jr,
    input  logic        ex_jump,
    input  logic        ex_branch,
    input  logic        ex_zero,
    input  logic [31:0] ex_branch_off,
    input  logic [25:0] ex_jump_idx,
    input  logic [31:0] ex_jr_addr,
    output logic [31:0] next_pc
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Branch offset is in words; the shift drops the top two bits, which is
    // exactly the mod 2^32 behaviour wanted for the add.
    assign branch_target = pc_plus4 + {ex_branch_off[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], ex_jump_idx, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (ex_jr) begin
            next_pc = ex_jr_addr;
        end else if (ex_jump) begin
            next_pc = jump_target;
        end else if (ex_branch && ex_zero) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch/commit controller owning the architectural PC.
// Optional target alignment trap: define PC_ALIGN_CHECK_EN.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          CNT_W         = 32,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_out,
    output logic             instr_valid,
    input  logic             ex_done,
    input  logic             ex_jump,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic             ex_jr,
    input  logic [31:0]      ex_branch_off,
    input  logic [25:0]      ex_jump_idx,
    input  logic [31:0]      ex_jr_addr,
    input  logic             ex_halt,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted,
    output logic             fetch_err,
    output logic             misalign_err,
    output state_t           dbg_state
);

    localparam int WAIT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

    state_t            state;
    logic [31:0]       pc;
    logic [31:0]       instr_q;
    logic              instr_valid_q;
    logic [CNT_W-1:0]  retire_q;
    logic              fetch_err_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       next_pc;

    assign pc_plus4 = pc + PC_STEP;

    pc_next_calc u_next (
        .pc_plus4      (pc_plus4),
        .ex_jr         (ex_jr),
        .ex_jump       (ex_jump),
        .ex_branch     (ex_branch),
        .ex_zero       (ex_zero),
        .ex_branch_off (ex_branch_off),
        .ex_jump_idx   (ex_jump_idx),
        .ex_jr_addr    (ex_jr_addr),
        .next_pc       (next_pc)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            retire_q      <= '0;
            fetch_err_q   <= 1'b0;
            wait_cnt      <= '0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= S_EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // This is the FETCH_TIMEOUT-th cycle without ready.
                        fetch_err_q <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (ex_done) begin
                        retire_q      <= retire_q + CNT_W'(1);
                        instr_valid_q <= 1'b0;
                        if (ex_halt) begin
                            state <= S_HALT;
`ifdef PC_ALIGN_CHECK_EN
                        end else if (next_pc[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                            state      <= S_HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= S_FETCH;
                        end
`else
                        end else begin
                            pc    <= align_word(next_pc);
                            state <= S_FETCH;
                        end
`endif
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_out   = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc;
    assign retire_cnt  = retire_q;
    assign halted      = (state == S_HALT);
    assign fetch_err   = fetch_err_q;
    assign dbg_state   = state;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: randomized imem/datapath driver,
// reference next-PC model, and a monitor checking each fetch and commit.
module tb_pc_fetch_sequencer;
  import pc_fetch_sequencer_pkg::*;

  localparam int W = 65;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        ex_done;
  logic        ex_jump;
  logic        ex_branch;
  logic        ex_zero;
  logic        ex_jr;
  logic [31:0] ex_branch_off;
  logic [25:0] ex_jump_idx;
  logic [31:0] ex_jr_addr;
  logic        ex_halt;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] retire_cnt;
  logic        halted;
  logic        fetch_err;
  logic        misalign_err;
  state_t      dbg_state;

  pc_fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .ex_done       (ex_done),
    .ex_jump       (ex_jump),
    .ex_branch     (ex_branch),
    .ex_zero       (ex_zero),
    .ex_jr         (ex_jr),
    .ex_branch_off (ex_branch_off),
    .ex_jump_idx   (ex_jump_idx),
    .ex_jr_addr    (ex_jr_addr),
    .ex_halt       (ex_halt),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .retire_cnt    (retire_cnt),
    .halted        (halted),
    .fetch_err     (fetch_err),
    .misalign_err  (misalign_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected commit = {halted, retire_cnt, pc}
  logic [W-1:0]  exp_q[$];
  logic [31:0]   exp_instr_q[$];

  logic [31:0] model_pc;
  logic [31:0] model_cnt;
  logic        model_halt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    model_pc   = 32'h0000_0000;
    model_cnt  = 32'd0;
    model_halt = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic junk_ex();
    ex_jump       = 1'($urandom_range(0, 1));
    ex_branch     = 1'($urandom_range(0, 1));
    ex_zero       = 1'($urandom_range(0, 1));
    ex_jr         = 1'($urandom_range(0, 1));
    ex_halt       = 1'($urandom_range(0, 1));
    ex_branch_off = $urandom;
    ex_jump_idx   = 26'($urandom);
    ex_jr_addr    = $urandom;
  endtask

  // ---------------- monitor ----------------
  logic last_rst = 1'b1;
  logic prev_valid = 1'b0;

  always @(posedge clk) last_rst <= rst;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [31:0]  ei;
    if (!last_rst) begin
      if (!prev_valid && instr_valid) begin
        if (exp_instr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL instr_unexpected actual=%h required=none", instr_out);
        end else begin
          ei = exp_instr_q.pop_front();
          check("instr_out", instr_out, ei);
        end
      end
      if (prev_valid && !instr_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL commit_unexpected actual_pc=%h required=none", pc_out);
        end else begin
          e = exp_q.pop_front();
          check("commit_pc", pc_out, e[31:0]);
          check("commit_retire_cnt", retire_cnt, e[63:32]);
          check("commit_halted", {31'b0, halted}, {31'b0, e[64]});
        end
      end
    end
    prev_valid = instr_valid;
  end

  // ---------------- driver ----------------
  task automatic run_instr(input int rdly, input int ddly,
                           input logic jr, input logic jump, input logic br,
                           input logic zero, input logic hlt,
                           input logic [31:0] off, input logic [31:0] jaddr,
                           input logic [25:0] idx);
    logic [31:0] word;
    logic [31:0] pc4;
    logic [31:0] nxt;
    check("imem_req_fetch", {31'b0, imem_req}, 32'd1);
    check("imem_addr", imem_addr, model_pc);
    check("pc_plus4", pc_plus4, model_pc + 32'd4);
    for (int i = 0; i < rdly; i++) begin
      imem_ready = 1'b0;
      ex_done    = 1'($urandom_range(0, 1));
      junk_ex();
      tick();
    end
    word       = $urandom;
    imem_ready = 1'b1;
    imem_rdata = word;
    ex_done    = 1'b0;
    exp_instr_q.push_back(word);
    tick();
    for (int i = 0; i < ddly; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      ex_done    = 1'b0;
      junk_ex();
      tick();
    end
    ex_jr = jr; ex_jump = jump; ex_branch = br; ex_zero = zero; ex_halt = hlt;
    ex_branch_off = off; ex_jr_addr = jaddr; ex_jump_idx = idx;
    ex_done = 1'b1;

    pc4 = model_pc + 32'd4;
    if (jr)               nxt = jaddr;
    else if (jump)        nxt = (pc4 & 32'hF000_0000) | ({6'b0, idx} * 32'd4);
    else if (br && zero)  nxt = pc4 + off * 32'd4;
    else                  nxt = pc4;
    model_cnt = model_cnt + 32'd1;
    if (hlt) begin
      model_halt = 1'b1;
    end else begin
`ifdef PC_ALIGN_CHECK_EN
      if (nxt % 4 != 0) model_halt = 1'b1;
      else              model_pc = nxt;
`else
      model_pc = nxt - (nxt % 4);
`endif
    end
    exp_q.push_back({model_halt, model_cnt, model_pc});
    tick();
    ex_done    = 1'b0;
    imem_ready = 1'b0;
  endtask

  task automatic run_simple(input logic jr, input logic jump, input logic br,
                            input logic zero, input logic [31:0] off,
                            input logic [31:0] jaddr, input logic [25:0] idx);
    run_instr($urandom_range(0, 3), $urandom_range(0, 3), jr, jump, br, zero, 1'b0,
              off, jaddr, idx);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] saved_pc;
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; ex_done = 1'b0;
    ex_jump = 0; ex_branch = 0; ex_zero = 0; ex_jr = 0; ex_halt = 0;
    ex_branch_off = '0; ex_jump_idx = '0; ex_jr_addr = '0;
    model_reset();

    apply_reset();
    check("rst_pc", pc_out, 32'h0);
    check("rst_retire_cnt", retire_cnt, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("rst_misalign_err", {31'b0, misalign_err}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, S_FETCH});

    // minimum latency, sequential
    run_instr(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
    // branch taken / not taken from 0x10, jr priority, jump, wrap
    run_simple(1, 0, 0, 0, 32'h0, 32'h10, 26'h0);
    run_simple(0, 0, 1, 1, 32'hFFFF_FFFE, 32'h0, 26'h0);
    run_simple(1, 0, 0, 0, 32'h0, 32'h10, 26'h0);
    run_simple(0, 0, 1, 0, 32'hFFFF_FFFE, 32'h0, 26'h0);
    run_simple(1, 0, 0, 0, 32'h0, 32'h10, 26'h0);
    run_simple(1, 1, 1, 1, 32'h5, 32'h200, 26'h40);
    run_simple(0, 1, 1, 1, 32'h5, 32'h0, 26'h40);
    run_simple(1, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 26'h0);
    run_simple(0, 0, 0, 0, 32'h0, 32'h0, 26'h0);

    for (int n = 0; n < 40; n++) begin
      run_simple(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 128)) - 32'd64, $urandom & 32'hFFFF_FFFC,
                 26'($urandom));
    end

    // reset wins over a commit in the same cycle
    check("mid_imem_req", {31'b0, imem_req}, 32'd1);
    imem_ready = 1'b1; imem_rdata = $urandom;
    exp_instr_q.push_back(imem_rdata);
    tick();
    imem_ready = 1'b0;
    tick();
    ex_jr = 1'b1; ex_jr_addr = 32'h40; ex_halt = 1'b0; ex_done = 1'b1; rst = 1'b1;
    tick();
    ex_done = 1'b0; rst = 1'b0;
    model_reset();
    check("mid_rst_pc", pc_out, 32'h0);
    check("mid_rst_retire_cnt", retire_cnt, 32'd0);
    check("mid_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("mid_rst_state", {30'b0, dbg_state}, {30'b0, S_FETCH});

    for (int n = 0; n < 5; n++) begin
      run_simple(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                 32'($urandom_range(0, 16)), 32'h0, 26'($urandom_range(0, 255)));
    end

    // halt instruction: counted, pc held, sticks in S_HALT
    saved_pc = model_pc;
    run_instr(1, 2, 1, 1, 1, 1, 1, 32'h3, 32'h80, 26'h11);
    for (int i = 0; i < 5; i++) begin
      imem_ready = 1'b1; ex_done = 1'b1; junk_ex();
      tick();
    end
    imem_ready = 1'b0; ex_done = 1'b0;
    check("halt_imem_req", {31'b0, imem_req}, 32'd0);
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_pc", pc_out, saved_pc);
    check("halt_retire_cnt", retire_cnt, model_cnt);

    // misaligned jr target
    apply_reset();
    run_simple(1, 0, 0, 0, 32'h0, 32'h102, 26'h0);
`ifdef PC_ALIGN_CHECK_EN
    check("misalign_err", {31'b0, misalign_err}, 32'd1);
    check("misalign_pc", pc_out, 32'h0);
    check("misalign_halted", {31'b0, halted}, 32'd1);
`else
    check("misalign_err", {31'b0, misalign_err}, 32'd0);
    check("misalign_pc", pc_out, 32'h100);
    run_simple(0, 0, 0, 0, 32'h0, 32'h0, 26'h0);
`endif

    // fetch timeout
    apply_reset();
    check("post_rst_misalign_err", {31'b0, misalign_err}, 32'd0);
    imem_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      ex_done = 1'($urandom_range(0, 1)); junk_ex();
      tick();
    end
    ex_done = 1'b0;
    check("timeout_14_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("timeout_14_halted", {31'b0, halted}, 32'd0);
    tick();
    check("timeout_15_fetch_err", {31'b0, fetch_err}, 32'd1);
    check("timeout_15_halted", {31'b0, halted}, 32'd1);
    check("timeout_imem_req", {31'b0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0;
    check("timeout_sticky", {31'b0, fetch_err}, 32'd1);
    check("timeout_pc", pc_out, 32'h0);
    apply_reset();
    check("clr_fetch_err", {31'b0, fetch_err}, 32'd0);
    check("clr_halted", {31'b0, halted}, 32'd0);
    check("clr_pc", pc_out, 32'h0);

    tick();
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("exp_instr_q_drained", exp_instr_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
